// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module   : multicycle_ctrl
// Brief    : Main control sequencer for the multi-cycle RV32I core.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic       instr_done,
  output logic       illegal
);

  localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
  localparam logic [6:0] c_OP_STORE = 7'b0100011;
  localparam logic [6:0] c_OP_RTYPE = 7'b0110011;
  localparam logic [6:0] c_OP_ITYPE = 7'b0010011;
  localparam logic [6:0] c_OP_BR    = 7'b1100011;
  localparam logic [6:0] c_OP_JAL   = 7'b1101111;
  localparam logic [6:0] c_OP_JALR  = 7'b1100111;
  localparam logic [6:0] c_OP_LUI   = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC = 7'b0010111;

  localparam logic [2:0] c_ALU_ADD = 3'b000;
  localparam logic [2:0] c_ALU_SUB = 3'b001;
  localparam logic [2:0] c_ALU_AND = 3'b010;
  localparam logic [2:0] c_ALU_OR  = 3'b011;
  localparam logic [2:0] c_ALU_XOR = 3'b100;
  localparam logic [2:0] c_ALU_SLT = 3'b101;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR1    = 4'd11,
    S_JALR2    = 4'd12,
    S_LUI      = 4'd13,
    S_AUIPC    = 4'd14,
    S_ILLEGAL  = 4'd15
  } state_t;

  state_t     r_state;
  state_t     w_next;
  state_t     w_state;
  logic       w_f3_bad;
  logic [2:0] w_alu_funct;

  assign w_f3_bad = (funct3 == 3'b001) || (funct3 == 3'b011) || (funct3 == 3'b101);

  always_comb begin
    case (funct3)
      3'b000:  w_alu_funct = (op[5] & funct7b5) ? c_ALU_SUB : c_ALU_ADD;
      3'b010:  w_alu_funct = c_ALU_SLT;
      3'b100:  w_alu_funct = c_ALU_XOR;
      3'b110:  w_alu_funct = c_ALU_OR;
      3'b111:  w_alu_funct = c_ALU_AND;
      default: w_alu_funct = c_ALU_ADD;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (op)
          c_OP_LOAD, c_OP_STORE: w_next = S_MEMADR;
          c_OP_RTYPE: w_next = w_f3_bad ? S_ILLEGAL : S_EXECR;
          c_OP_ITYPE: w_next = w_f3_bad ? S_ILLEGAL : S_EXECI;
          c_OP_BR:    w_next = (funct3[2:1] == 2'b00) ? S_BRANCH : S_ILLEGAL;
          c_OP_JAL:   w_next = S_JAL;
          c_OP_JALR:  w_next = S_JALR1;
          c_OP_LUI:   w_next = S_LUI;
          c_OP_AUIPC: w_next = S_AUIPC;
          default:    w_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR:  w_next = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: w_next = S_MEMWB;
      S_EXECR, S_EXECI, S_JAL, S_JALR2, S_AUIPC: w_next = S_ALUWB;
      S_JALR1:   w_next = S_JALR2;
      S_MEMWB, S_MEMWRITE, S_ALUWB, S_BRANCH, S_LUI: w_next = S_FETCH;
      S_ILLEGAL: w_next = S_ILLEGAL;
      default:   w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  // While in reset the selects present FETCH values regardless of the
  // state register, so the datapath sees a clean fetch on release.
  assign w_state = rst_n ? r_state : S_FETCH;

  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = c_ALU_ADD;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (w_state)
      S_FETCH: begin
        IRWrite   = 1'b1;
        PCWrite   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_DECODE, S_AUIPC: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR, S_JALR1: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = w_alu_funct;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        MemWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = w_alu_funct;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = c_ALU_SUB;
        PCWrite    = Zero ^ funct3[0];
        instr_done = 1'b1;
      end
      S_JAL, S_JALR2: begin
        PCWrite = 1'b1;
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
      end
      S_LUI: begin
        ResultSrc  = 2'b11;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_ILLEGAL: illegal = 1'b1;
      default: ;
    endcase
    if (!rst_n) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
    end
  end

  always_comb begin
    case (op)
      c_OP_LOAD, c_OP_ITYPE, c_OP_JALR: ImmSrc = 3'b000;
      c_OP_STORE:                       ImmSrc = 3'b001;
      c_OP_BR:                          ImmSrc = 3'b010;
      c_OP_LUI, c_OP_AUIPC:             ImmSrc = 3'b011;
      c_OP_JAL:                         ImmSrc = 3'b100;
      default:                          ImmSrc = 3'b000;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// Module   : tb_multicycle_ctrl
// Brief    : Randomized instruction-level check of multicycle_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ALUControl, ImmSrc;
  logic       instr_done, illegal;
  logic [18:0] w_dut_vec;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .ImmSrc(ImmSrc), .instr_done(instr_done), .illegal(illegal)
  );

  assign w_dut_vec = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                      ALUSrcA, ALUSrcB, ALUControl, ImmSrc, instr_done, illegal};

  task automatic check_vec(input string tag, input logic [18:0] got, input logic [18:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%05h exp=%05h", tag, got, exp);
    end
  endtask

  // One entry per cycle an instruction spends in the controller.
  typedef enum int {
    ST_F, ST_D, ST_MA, ST_MR, ST_MWB, ST_MW, ST_ER, ST_EI,
    ST_WB, ST_BR, ST_JAL, ST_JR1, ST_JR2, ST_LUI, ST_AUI, ST_ILL
  } step_e;

  step_e seq[$];

  function automatic logic [18:0] pack(input logic pcw, adr, mw, irw, rw,
                                       input logic [1:0] rs, sa, sb,
                                       input logic [2:0] alu, imm,
                                       input logic done, ill);
    return {pcw, adr, mw, irw, rw, rs, sa, sb, alu, imm, done, ill};
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] o);
    case (o)
      7'b0100011:             return 3'd1;
      7'b1100011:             return 3'd2;
      7'b0110111, 7'b0010111: return 3'd3;
      7'b1101111:             return 3'd4;
      default:                return 3'd0;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (f3)
      3'd0:    return (o[5] && f7) ? 3'd1 : 3'd0;
      3'd2:    return 3'd5;
      3'd4:    return 3'd4;
      3'd6:    return 3'd3;
      3'd7:    return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [18:0] expect_step(input step_e s, input logic [6:0] o,
                                              input logic [2:0] f3, input logic f7, input logic z);
    logic [2:0] im;
    im = imm_of(o);
    case (s)
      ST_F:          return pack(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'd0, im, 0, 0);
      ST_D, ST_AUI:  return pack(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'd0, im, 0, 0);
      ST_MA, ST_JR1: return pack(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'd0, im, 0, 0);
      ST_MR:         return pack(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'd0, im, 0, 0);
      ST_MWB:        return pack(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'd0, im, 1, 0);
      ST_MW:         return pack(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'd0, im, 1, 0);
      ST_ER:         return pack(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, alu_of(o, f3, f7), im, 0, 0);
      ST_EI:         return pack(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, alu_of(o, f3, f7), im, 0, 0);
      ST_WB:         return pack(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'd0, im, 1, 0);
      ST_BR:         return pack(z ^ f3[0], 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'd1, im, 1, 0);
      ST_JAL, ST_JR2: return pack(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'd0, im, 0, 0);
      ST_LUI:        return pack(0, 0, 0, 0, 1, 2'b11, 2'b00, 2'b00, 3'd0, im, 1, 0);
      default:       return pack(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'd0, im, 0, 1);
    endcase
  endfunction

  function automatic logic [18:0] reset_vec(input logic [6:0] o);
    return pack(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'd0, imm_of(o), 0, 0);
  endfunction

  function automatic void build_seq(input logic [6:0] o, input logic [2:0] f3);
    logic f3_bad;
    f3_bad = (f3 == 3'd1) || (f3 == 3'd3) || (f3 == 3'd5);
    seq = '{ST_F, ST_D};
    case (o)
      7'b0000011: begin seq.push_back(ST_MA); seq.push_back(ST_MR); seq.push_back(ST_MWB); end
      7'b0100011: begin seq.push_back(ST_MA); seq.push_back(ST_MW); end
      7'b0110011: begin
        if (f3_bad) seq.push_back(ST_ILL);
        else begin seq.push_back(ST_ER); seq.push_back(ST_WB); end
      end
      7'b0010011: begin
        if (f3_bad) seq.push_back(ST_ILL);
        else begin seq.push_back(ST_EI); seq.push_back(ST_WB); end
      end
      7'b1100011: seq.push_back((f3 <= 3'd1) ? ST_BR : ST_ILL);
      7'b1101111: begin seq.push_back(ST_JAL); seq.push_back(ST_WB); end
      7'b1100111: begin seq.push_back(ST_JR1); seq.push_back(ST_JR2); seq.push_back(ST_WB); end
      7'b0110111: seq.push_back(ST_LUI);
      7'b0010111: begin seq.push_back(ST_AUI); seq.push_back(ST_WB); end
      default:    seq.push_back(ST_ILL);
    endcase
    // Illegal is sticky: watch it hold for a few more cycles.
    if (seq[seq.size()-1] == ST_ILL) begin
      seq.push_back(ST_ILL);
      seq.push_back(ST_ILL);
    end
  endfunction

  // Entered and left at posedge+1.
  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      check_vec($sformatf("reset op=%07b cyc%0d", op, k), w_dut_vec, reset_vec(op));
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
  endtask

  // Entered at posedge+1 with the controller in FETCH.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic z, input bit allow_abort);
    int abort_at;
    op = o; funct3 = f3; funct7b5 = f7; Zero = z;
    build_seq(o, f3);
    abort_at = -1;
    if (allow_abort && $urandom_range(0, 7) == 0)
      abort_at = int'($urandom_range(0, seq.size() - 1));
    for (int i = 0; i < seq.size(); i++) begin
      @(negedge clk);
      check_vec($sformatf("op=%07b f3=%0d f7=%0d z=%0d cyc%0d", o, f3, f7, z, i),
                w_dut_vec, expect_step(seq[i], o, f3, f7, z));
      @(posedge clk);
      #1;
      if (i == abort_at) begin
        do_reset(1);
        return;
      end
    end
    if (seq[seq.size()-1] == ST_ILL) do_reset(1);
  endtask

  logic [6:0] op_pool [0:10];

  initial begin
    op_pool = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011, 7'b0001111};
    rst_n = 1'b0; op = 7'b0000011; funct3 = 3'd2; funct7b5 = 1'b0; Zero = 1'b0;
    #1;
    do_reset(2);

    run_instr(7'b0000011, 3'd2, 1'b0, 1'b0, 1'b0);   // lw
    run_instr(7'b0100011, 3'd2, 1'b0, 1'b0, 1'b0);   // sw
    run_instr(7'b1100011, 3'd0, 1'b0, 1'b1, 1'b0);   // beq taken
    run_instr(7'b1100011, 3'd1, 1'b0, 1'b1, 1'b0);   // bne not taken
    run_instr(7'b0110011, 3'd0, 1'b1, 1'b0, 1'b0);   // sub
    run_instr(7'b0010011, 3'd0, 1'b1, 1'b0, 1'b0);   // addi, bit 30 set
    run_instr(7'b0110011, 3'd7, 1'b0, 1'b0, 1'b0);   // and
    run_instr(7'b1101111, 3'd0, 1'b0, 1'b0, 1'b0);   // jal
    run_instr(7'b1100111, 3'd0, 1'b0, 1'b0, 1'b0);   // jalr
    run_instr(7'b0110111, 3'd0, 1'b0, 1'b0, 1'b0);   // lui
    run_instr(7'b0010111, 3'd0, 1'b0, 1'b0, 1'b0);   // auipc
    run_instr(7'b1110011, 3'd0, 1'b0, 1'b0, 1'b0);   // ecall -> illegal
    run_instr(7'b0110011, 3'd5, 1'b0, 1'b0, 1'b0);   // srl unsupported
    run_instr(7'b1100011, 3'd4, 1'b0, 1'b0, 1'b0);   // blt unsupported

    for (int n = 0; n < 400; n++) begin
      logic [6:0] o;
      int sel;
      sel = int'($urandom_range(0, 11));
      o = (sel == 11) ? 7'($urandom) : op_pool[sel];
      run_instr(o, 3'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
